mem_lsu_access: RTL and testbench
=================================

// Module: mem_lsu_access
// PURPOSE
//  MEM-stage load/store sequencer; drives ram_stall_valid_mem to pipeline control.
//  Takes one op from the EX/MEM register and issues one bus request to the arbiter.
//  Holds the pipeline until the arbiter reports read or write completion.
//  Returns load data aligned and extended to the MEM/WB register.
// PARAMETERS
//  ADDR_W  32  bus address width
//  DATA_W  64  data width; only 64 supported (8-bit strobe)
// PORTS
//  clk                  in   1       clock
//  rst                  in   1       sync active-high reset
//  mem_valid_i          in   1       EX/MEM holds a valid instruction
//  mem_ren_i            in   1       load
//  mem_wen_i            in   1       store (ren&wen never both 1)
//  mem_size_i           in   2       0=B 1=H 2=W 3=D
//  mem_unsigned_i       in   1       zero-extend load
//  mem_addr_i           in   ADDR_W  byte address
//  mem_wdata_i          in   64      store data, LSB-justified
//  mem_stall_i          in   1       pipeline-control stall bit freezing EX/MEM
//  flush_i              in   1       pipeline-control flush bit for the MEM stage
//  arb_req_o            out  1       bus request, held until completion
//  arb_we_o             out  1       1=write
//  arb_addr_o           out  ADDR_W  {addr[ADDR_W-1:3],3'b0}
//  arb_wdata_o          out  64      wdata << 8*addr[2:0]
//  arb_wstrb_o          out  8       size mask << addr[2:0], truncated to 8 bits
//  arb_rdata_i          in   64      read data
//  arb_rdata_ready_i    in   1       read completes this cycle
//  arb_wdata_ready_i    in   1       write completes this cycle
//  ram_stall_valid_mem_o out 1       stall request to pipeline control
//  load_data_o          out  64      extended load result
//  load_data_valid_o    out  1       load_data_o valid (DONE, load op)
//  misalign_o           out  1       misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  States: IDLE, RD_WAIT, WR_WAIT, DONE.
//  Reset: state=IDLE; all outputs 0; flushed flag 0. Reset mid-transaction aborts to IDLE.
//  IDLE: accept when mem_valid_i&(ren|wen)&!flush_i (and not misaligned when checked).
//    On accept: ram_stall_valid_mem_o=1 combinationally in the same cycle.
//    Next state is RD_WAIT or WR_WAIT; address, data, strobe, size and sign are latched.
//  RD_WAIT/WR_WAIT: arb_req_o=1 (registered) and ram_stall_valid_mem_o=1.
//    Request fields stay stable until ready. Ready in the first WAIT cycle gives a 1-cycle wait.
//    On arb_rdata_ready_i (RD) or arb_wdata_ready_i (WR): arb_req_o drops next cycle; go DONE.
//    RD: load_data_o <= ext(arb_rdata_i >> 8*addr[2:0]).
//      size B/H/W: sign- or zero-extend from bit 7/15/31 per mem_unsigned. D: unchanged.
//    Ready outside a WAIT state is ignored.
//  flush_i during WAIT: the bus transaction is never abandoned; flushed flag is set.
//    On ready, go IDLE (not DONE); no load_data_valid_o.
//    ram_stall_valid_mem_o=0 from the completion cycle on.
//  DONE: ram_stall_valid_mem_o=0; load_data_valid_o=1 only if the op was a load.
//    mem_stall_i=1: stay in DONE; result held; the op is not reissued.
//    mem_stall_i=0 or flush_i=1: go IDLE.
//  Latency: load with bus wait N -> stall asserted N+1 cycles; DONE on cycle N+2.
//  Only one outstanding request. No new op is sampled outside IDLE.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    Misaligned if addr[0] for H, addr[1:0]!=0 for W, addr[2:0]!=0 for D.
//    In IDLE, misalign_o=1 combinationally; no request; no stall; state stays IDLE.
//  Not defined: misalign_o tied 0.
//    Access issues normally; strobe bits beyond byte 7 dropped; read bytes beyond byte 7 read as 0.
// TESTING
//  1. LW addr 0x8000_0004, rdata 0xFFFF_FFFF_8000_0000, ready 2 cycles later
//     -> stall 3 cycles, load_data_o=0xFFFF_FFFF_FFFF_FFFF; LWU gives 0x0000_0000_FFFF_FFFF.
//  2. SB addr 0x8000_0003 wdata 0xAB, wready 1st cycle
//     -> wstrb=0x08, wdata=0x0000_0000_AB00_0000, arb_req 1 cycle, no load_valid.
//  3. Load, flush_i in RD_WAIT, ready 3 cycles later
//     -> arb_req held until ready; then IDLE, load_data_valid_o never 1.
//  4. Load completes with mem_stall_i=1 for 2 cycles
//     -> DONE held 3 cycles, load_data_valid_o=1 throughout, exactly one arb_req burst.
//  5. rst pulse in WR_WAIT -> next cycle state IDLE, arb_req_o=0, stall=0.
//  6. CHECK_EN: LD addr 0x...4 -> misalign_o=1, arb_req_o=0, stall=0;
//     without CHECK_EN: request issued, wstrb/read truncated.

Source files
------------

// File: rtl/mem_lsu_access.sv
// mem_lsu_access: MEM-stage load/store sequencer.
// Accepts one load or store from the EX/MEM register, issues a single bus
// request to the arbiter, stalls the pipeline until the arbiter completes,
// and returns the load result shifted and sign/zero-extended for MEM/WB.
//
// Optional build macro: MEM_MISALIGN_CHECK_EN
//   defined   -> naturally misaligned accesses are refused in IDLE and flagged
//                on misalign_o (no request, no stall).
//   undefined -> misalign_o tied 0; misaligned accesses issue normally, with
//                strobe bits and read bytes beyond byte 7 dropped.
//
// Bus handshake: arb_req_o is a level request. Once raised, arb_req_o and all
// request fields (arb_we_o, arb_addr_o, arb_wdata_o, arb_wstrb_o) stay stable
// until the arbiter pulses arb_rdata_ready_i (read) or arb_wdata_ready_i
// (write) for one cycle; that cycle completes the transfer and arb_req_o drops
// on the following edge. Ready pulses seen outside a WAIT state are ignored.
//
// fsm_state_o exposes the sequencer state: 0=IDLE 1=RD_WAIT 2=WR_WAIT 3=DONE.

module mem_lsu_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic              mem_ren_i,
    input  logic              mem_wen_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic              arb_req_o,
    output logic              arb_we_o,
    output logic [ADDR_W-1:0] arb_addr_o,
    output logic [DATA_W-1:0] arb_wdata_o,
    output logic [7:0]        arb_wstrb_o,
    input  logic [DATA_W-1:0] arb_rdata_i,
    input  logic              arb_rdata_ready_i,
    input  logic              arb_wdata_ready_i,
    output logic              ram_stall_valid_mem_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              load_data_valid_o,
    output logic              misalign_o,
    output logic [1:0]        fsm_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    logic        flushed_q;   // op was flushed while its bus transfer was in flight
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [2:0]  off_q;       // byte offset inside the 64-bit bus word

    logic        op_present;
    logic        accept;
    logic        bus_done;
    logic        kill_now;
    logic [7:0]  size_mask;
    logic [15:0] strb_wide;
    logic [DATA_W-1:0] rdata_shifted;

    assign fsm_state_o = state;
    assign op_present  = mem_valid_i & (mem_ren_i | mem_wen_i);

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned;

    // Natural alignment: H on 2, W on 4, D on 8 byte boundaries.
    always_comb begin
        misaligned = 1'b0;
        case (mem_size_i)
            2'd1:    misaligned = mem_addr_i[0];
            2'd2:    misaligned = |mem_addr_i[1:0];
            2'd3:    misaligned = |mem_addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign misalign_o = !rst && (state == IDLE) && op_present && misaligned;
`else
    assign misalign_o = 1'b0;
`endif

    assign accept = !rst && (state == IDLE) && op_present && !flush_i && !misalign_o;

    // Completion of the outstanding transfer in the matching WAIT state only.
    assign bus_done = ((state == RD_WAIT) && arb_rdata_ready_i) ||
                      ((state == WR_WAIT) && arb_wdata_ready_i);

    // A flush seen earlier or in the completion cycle itself discards the op.
    assign kill_now = flushed_q || flush_i;

    // Byte-enable pattern for the access size before shifting into place.
    always_comb begin
        size_mask = 8'h00;
        case (mem_size_i)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Shifted strobe kept 16 bits wide so bytes past lane 7 simply fall off.
    assign strb_wide = {8'h00, size_mask} << mem_addr_i[2:0];

    // Right-justify the addressed bytes; lanes past byte 7 shift in as zero.
    assign rdata_shifted = arb_rdata_i >> {off_q, 3'b000};

    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              is_unsigned
    );
        logic [DATA_W-1:0] res;
        case (size)
            2'd0:    res = {{56{~is_unsigned & raw[7]}},  raw[7:0]};
            2'd1:    res = {{48{~is_unsigned & raw[15]}}, raw[15:0]};
            2'd2:    res = {{32{~is_unsigned & raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Stall request: raised in the accept cycle and throughout the wait,
    // dropped in the completion cycle of a flushed op and in DONE.
    always_comb begin
        ram_stall_valid_mem_o = 1'b0;
        case (state)
            IDLE:    ram_stall_valid_mem_o = accept;
            RD_WAIT: ram_stall_valid_mem_o = !(arb_rdata_ready_i && kill_now);
            WR_WAIT: ram_stall_valid_mem_o = !(arb_wdata_ready_i && kill_now);
            default: ram_stall_valid_mem_o = 1'b0;
        endcase
        if (rst) begin
            ram_stall_valid_mem_o = 1'b0;
        end
    end

    // Sequencer: latch the op on accept, hold the request until ready,
    // capture load data, and wait in DONE while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            flushed_q         <= 1'b0;
            size_q            <= 2'd0;
            unsigned_q        <= 1'b0;
            off_q             <= 3'd0;
            arb_req_o         <= 1'b0;
            arb_we_o          <= 1'b0;
            arb_addr_o        <= '0;
            arb_wdata_o       <= '0;
            arb_wstrb_o       <= 8'h00;
            load_data_o       <= '0;
            load_data_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_data_valid_o <= 1'b0;
                    if (accept) begin
                        state       <= mem_ren_i ? RD_WAIT : WR_WAIT;
                        flushed_q   <= 1'b0;
                        size_q      <= mem_size_i;
                        unsigned_q  <= mem_unsigned_i;
                        off_q       <= mem_addr_i[2:0];
                        arb_req_o   <= 1'b1;
                        arb_we_o    <= mem_wen_i;
                        arb_addr_o  <= {mem_addr_i[ADDR_W-1:3], 3'b000};
                        arb_wdata_o <= mem_wdata_i << {mem_addr_i[2:0], 3'b000};
                        arb_wstrb_o <= strb_wide[7:0];
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (bus_done) begin
                        arb_req_o <= 1'b0;
                        if (kill_now) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            if (state == RD_WAIT) begin
                                load_data_o       <= extend_load(rdata_shifted, size_q, unsigned_q);
                                load_data_valid_o <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (flush_i || !mem_stall_i) begin
                        state             <= IDLE;
                        load_data_valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_access.sv
// Testbench for mem_lsu_access: scenario tasks drive ops and emulate the bus
// arbiter; a scoreboard queue holds expected load results that are popped
// when load_data_valid_o rises. Honours MEM_MISALIGN_CHECK_EN like the RTL.

module tb_mem_lsu_access;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid_i, mem_ren_i, mem_wen_i, mem_unsigned_i;
  logic [1:0]        mem_size_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_stall_i, flush_i;
  logic              arb_req_o, arb_we_o;
  logic [ADDR_W-1:0] arb_addr_o;
  logic [DATA_W-1:0] arb_wdata_o;
  logic [7:0]        arb_wstrb_o;
  logic [DATA_W-1:0] arb_rdata_i;
  logic              arb_rdata_ready_i, arb_wdata_ready_i;
  logic              ram_stall_valid_mem_o;
  logic [DATA_W-1:0] load_data_o;
  logic              load_data_valid_o, misalign_o;
  logic [1:0]        fsm_state_o;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  // results captured by the last do_op call
  int          stall_cnt, req_cnt, done_cnt, lv_cnt, mis_cnt;
  bit          timed_out, got_cap;
  logic [7:0]  cap_strb;
  logic [63:0] cap_wdata;
  logic [31:0] cap_addr;
  logic        cap_we;

  // clock / reset
  always #5 clk = ~clk;

  mem_lsu_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .arb_req_o(arb_req_o), .arb_we_o(arb_we_o), .arb_addr_o(arb_addr_o),
    .arb_wdata_o(arb_wdata_o), .arb_wstrb_o(arb_wstrb_o),
    .arb_rdata_i(arb_rdata_i), .arb_rdata_ready_i(arb_rdata_ready_i),
    .arb_wdata_ready_i(arb_wdata_ready_i),
    .ram_stall_valid_mem_o(ram_stall_valid_mem_o),
    .load_data_o(load_data_o), .load_data_valid_o(load_data_valid_o),
    .misalign_o(misalign_o), .fsm_state_o(fsm_state_o)
  );

  // reference models, written byte by byte
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [63:0] r;
    int n;
    r = '0;
    n = 1 << size;
    for (int i = 0; i < 8; i++)
      if (i < n && int'(off) + i < 8) r[8*i +: 8] = rdata[8*(int'(off) + i) +: 8];
    if (!uns && size != 2'd3) begin
      logic s;
      s = r[8*n - 1];
      for (int b = 8*n; b < 64; b++) r[b] = s;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] s;
    int n;
    s = '0;
    n = 1 << size;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off) && i < int'(off) + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) w[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
    return w;
  endfunction

  // scoreboard: pop one expected load result per rising load_data_valid_o
  logic prev_lv = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_lv = 1'b0;
    end else begin
      if (load_data_valid_o && !prev_lv) begin
        logic [63:0] e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_load got=%h want=none", load_data_o);
        end else begin
          e = exp_q.pop_front();
          if (load_data_o !== e) begin
            bad++;
            $display("FAIL sb_load_data got=%h want=%h", load_data_o, e);
          end
        end
      end
      prev_lv = load_data_valid_o;
    end
  end

  task automatic idle_inputs();
    mem_valid_i = 0; mem_ren_i = 0; mem_wen_i = 0; mem_unsigned_i = 0;
    mem_size_i = 0; mem_addr_i = '0; mem_wdata_i = '0;
    mem_stall_i = 0; flush_i = 0;
    arb_rdata_i = '0; arb_rdata_ready_i = 0; arb_wdata_ready_i = 0;
  endtask

  // driver + arbiter emulation; called and left at posedge+1
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int wait_n, input int hold_n,
                       input bit flush_wait, input bit expect_load);
    int wc;
    wc = 0;
    stall_cnt = 0; req_cnt = 0; done_cnt = 0; lv_cnt = 0; mis_cnt = 0;
    got_cap = 0; cap_strb = '0; cap_wdata = '0; cap_addr = '0; cap_we = 0;
    timed_out = 1;
    if (expect_load) exp_q.push_back(model_load(rdata, addr[2:0], size, uns));
    mem_valid_i = 1; mem_ren_i = !we; mem_wen_i = we; mem_size_i = size;
    mem_unsigned_i = uns; mem_addr_i = addr; mem_wdata_i = wdata;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ram_stall_valid_mem_o) stall_cnt++;
      if (misalign_o) mis_cnt++;
      if (fsm_state_o == 2'd3) done_cnt++;
      if (load_data_valid_o) lv_cnt++;
      if (arb_req_o) begin
        req_cnt++;
        if (!got_cap) begin
          got_cap = 1; cap_strb = arb_wstrb_o; cap_wdata = arb_wdata_o;
          cap_addr = arb_addr_o; cap_we = arb_we_o;
        end
      end
      @(posedge clk); #1;
      mem_valid_i = 0; mem_ren_i = 0; mem_wen_i = 0;
      if (fsm_state_o == 2'd0) begin
        timed_out = 0;
        flush_i = 0; mem_stall_i = 0; arb_rdata_ready_i = 0; arb_wdata_ready_i = 0;
        break;
      end
      if (arb_req_o) wc++;
      arb_rdata_ready_i = !we && arb_req_o && (wc == wait_n);
      arb_wdata_ready_i =  we && arb_req_o && (wc == wait_n);
      arb_rdata_i = arb_rdata_ready_i ? rdata : {$urandom, $urandom};
      flush_i = flush_wait && arb_req_o;
      mem_stall_i = (fsm_state_o == 2'd3) && (done_cnt < hold_n);
    end
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL op_timeout state=%0d want=0", fsm_state_o);
      idle_inputs();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    mem_valid_i = 1; mem_ren_i = 1; mem_size_i = 2'd3; mem_addr_i = 32'h8000_0001;
    arb_rdata_ready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (fsm_state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", fsm_state_o); end
    total++; if (arb_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", arb_req_o); end
    total++; if (ram_stall_valid_mem_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", ram_stall_valid_mem_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b want=0", misalign_o); end
    total++; if ({arb_we_o, arb_addr_o, arb_wdata_o, arb_wstrb_o, load_data_o, load_data_valid_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got_nonzero addr=%h strb=%h ld=%h", arb_addr_o, arb_wstrb_o, load_data_o);
    end
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_stray_ready();
    arb_rdata_ready_i = 1; arb_wdata_ready_i = 1; arb_rdata_i = 64'hDEAD_BEEF_0000_1111;
    @(posedge clk); #1;
    arb_rdata_ready_i = 0; arb_wdata_ready_i = 0;
    @(negedge clk);
    total++; if (fsm_state_o !== 2'd0 || load_data_valid_o !== 1'b0) begin
      bad++; $display("FAIL stray_ready state=%0d lv=%b want=0/0", fsm_state_o, load_data_valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_ext();
    do_op(0, 2'd2, 0, 32'h8000_0004, '0, 64'hFFFF_FFFF_8000_0000, 2, 0, 0, 1);
    total++; if (stall_cnt !== 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=3", stall_cnt); end
    total++; if (req_cnt !== 2) begin bad++; $display("FAIL lw_req_cycles got=%0d want=2", req_cnt); end
    total++; if (cap_addr !== 32'h8000_0000 || cap_we !== 1'b0) begin
      bad++; $display("FAIL lw_req_fields addr=%h we=%b want=80000000/0", cap_addr, cap_we);
    end
    total++; if (done_cnt !== 1 || lv_cnt !== 1) begin bad++; $display("FAIL lw_done done=%0d lv=%0d want=1/1", done_cnt, lv_cnt); end
    do_op(0, 2'd2, 1, 32'h8000_0004, '0, 64'hFFFF_FFFF_8000_0000, 2, 0, 0, 1);
    do_op(0, 2'd0, 0, 32'h8000_0002, '0, 64'h0000_0000_0080_0000, 1, 0, 0, 1);
    do_op(0, 2'd1, 1, 32'h8000_0006, '0, 64'h9ABC_0000_0000_0000, 3, 0, 0, 1);
  endtask

  task automatic test_store_byte();
    do_op(1, 2'd0, 0, 32'h8000_0003, 64'hAB, '0, 1, 0, 0, 0);
    total++; if (cap_strb !== 8'h08) begin bad++; $display("FAIL sb_wstrb got=%h want=08", cap_strb); end
    total++; if (cap_wdata !== 64'h0000_0000_AB00_0000) begin bad++; $display("FAIL sb_wdata got=%h want=00000000ab000000", cap_wdata); end
    total++; if (req_cnt !== 1 || cap_we !== 1'b1) begin bad++; $display("FAIL sb_req req=%0d we=%b want=1/1", req_cnt, cap_we); end
    total++; if (lv_cnt !== 0 || stall_cnt !== 2) begin bad++; $display("FAIL sb_lv_stall lv=%0d stall=%0d want=0/2", lv_cnt, stall_cnt); end
  endtask

  task automatic test_flush_wait();
    do_op(0, 2'd3, 0, 32'h8000_0010, '0, 64'h0123_4567_89AB_CDEF, 3, 0, 1, 0);
    total++; if (req_cnt !== 3) begin bad++; $display("FAIL flush_req_held got=%0d want=3", req_cnt); end
    total++; if (lv_cnt !== 0 || done_cnt !== 0) begin bad++; $display("FAIL flush_no_result lv=%0d done=%0d want=0/0", lv_cnt, done_cnt); end
    total++; if (stall_cnt !== 3) begin bad++; $display("FAIL flush_stall got=%0d want=3", stall_cnt); end
  endtask

  task automatic test_done_hold();
    do_op(0, 2'd3, 0, 32'h8000_0020, '0, 64'hCAFE_F00D_1234_5678, 1, 2, 0, 1);
    total++; if (done_cnt !== 3 || lv_cnt !== 3) begin bad++; $display("FAIL hold_done done=%0d lv=%0d want=3/3", done_cnt, lv_cnt); end
    total++; if (req_cnt !== 1) begin bad++; $display("FAIL hold_one_burst got=%0d want=1", req_cnt); end
  endtask

  task automatic test_reset_mid();
    mem_valid_i = 1; mem_wen_i = 1; mem_size_i = 2'd3; mem_addr_i = 32'h8000_0040; mem_wdata_i = 64'h55;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total++; if (fsm_state_o !== 2'd2 || arb_req_o !== 1'b1) begin bad++; $display("FAIL rstmid_enter state=%0d req=%b want=2/1", fsm_state_o, arb_req_o); end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++; if (fsm_state_o !== 2'd0 || arb_req_o !== 1'b0 || ram_stall_valid_mem_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_abort state=%0d req=%b stall=%b want=0/0/0", fsm_state_o, arb_req_o, ram_stall_valid_mem_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    mem_valid_i = 1; mem_ren_i = 1; mem_size_i = 2'd3; mem_addr_i = 32'h8000_0004;
    @(negedge clk);
    total++; if (misalign_o !== 1'b1 || arb_req_o !== 1'b0 || ram_stall_valid_mem_o !== 1'b0) begin
      bad++; $display("FAIL misalign_flag mis=%b req=%b stall=%b want=1/0/0", misalign_o, arb_req_o, ram_stall_valid_mem_o);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total++; if (fsm_state_o !== 2'd0 || arb_req_o !== 1'b0) begin bad++; $display("FAIL misalign_idle state=%0d req=%b want=0/0", fsm_state_o, arb_req_o); end
    @(posedge clk); #1;
`else
    do_op(0, 2'd3, 0, 32'h8000_0004, '0, 64'h1122_3344_5566_7788, 1, 0, 0, 1);
    total++; if (mis_cnt !== 0 || req_cnt !== 1) begin bad++; $display("FAIL misalign_issue mis=%0d req=%0d want=0/1", mis_cnt, req_cnt); end
    total++; if (cap_strb !== 8'hF0) begin bad++; $display("FAIL misalign_ld_strb got=%h want=f0", cap_strb); end
    do_op(1, 2'd3, 0, 32'h8000_0004, 64'h1122_3344_5566_7788, '0, 2, 0, 0, 0);
    total++; if (cap_wdata !== 64'h5566_7788_0000_0000 || cap_strb !== 8'hF0) begin
      bad++; $display("FAIL misalign_sd wdata=%h strb=%h want=5566778800000000/f0", cap_wdata, cap_strb);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      logic we, uns;
      logic [1:0] sz;
      logic [2:0] off;
      logic [63:0] wd, rd;
      int wn;
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7));
`ifdef MEM_MISALIGN_CHECK_EN
      off = off & ~3'((1 << sz) - 1);
`endif
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      wn = $urandom_range(1, 3);
      do_op(we, sz, uns, {29'h1000_0100 + 29'(k), off}, wd, rd, wn, 0, 0, !we);
      total++; if (stall_cnt !== wn + 1 || req_cnt !== wn) begin
        bad++; $display("FAIL b2b_timing k=%0d stall=%0d req=%0d want=%0d/%0d", k, stall_cnt, req_cnt, wn + 1, wn);
      end
      if (we) begin
        total++; if (cap_strb !== model_strb(off, sz) || cap_wdata !== model_wdata(wd, off)) begin
          bad++; $display("FAIL b2b_store k=%0d strb=%h wdata=%h want=%h/%h", k, cap_strb, cap_wdata, model_strb(off, sz), model_wdata(wd, off));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stray_ready();
    test_load_ext();
    test_store_byte();
    test_flush_wait();
    test_done_hold();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
